// File: rtl/demux1to4_reg.sv
// Registered 1-to-4 demultiplexer.
// One input word is steered to one of four output lanes. Each lane is a
// 1-entry holding register with its own valid/ready handshake, so the four
// consumers can drain independently.
module demux1to4_reg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] Data_in,
    input  logic [1:0]       Sel,
    input  logic             In_valid,
    output logic             In_ready,
    output logic [WIDTH-1:0] Data_out0,
    output logic [WIDTH-1:0] Data_out1,
    output logic [WIDTH-1:0] Data_out2,
    output logic [WIDTH-1:0] Data_out3,
    output logic [3:0]       Out_valid,
    input  logic [3:0]       Out_ready,
    output logic [2:0]       Occ
);

    logic [3:0]       full_q, full_d;
    logic [WIDTH-1:0] data_q [4];
    logic [WIDTH-1:0] data_d [4];
    logic [2:0]       occ_q, occ_d;
    logic             accept;
    logic [3:0]       load;
    logic [3:0]       drain;

    // Handshake decode: a lane draining this cycle may be refilled in the same cycle.
    always_comb begin
        In_ready = ~full_q[Sel] | Out_ready[Sel];
        accept   = In_valid & In_ready;
        load     = accept ? (4'b0001 << Sel) : 4'b0000;
        drain    = full_q & Out_ready;
    end

    // Per-lane next state: a load wins over a drain, so the flag stays set on pass-through.
    always_comb begin
        full_d = full_q;
        for (int k = 0; k < 4; k++) begin
            data_d[k] = data_q[k];
            if (load[k]) begin
                data_d[k] = Data_in;
                full_d[k] = 1'b1;
            end else if (drain[k]) begin
                full_d[k] = 1'b0;
            end
        end
    end

    // Occupancy is the popcount of the next full flags, registered alongside them.
    always_comb begin
        occ_d = '0;
        for (int k = 0; k < 4; k++) begin
            occ_d = occ_d + {2'b00, full_d[k]};
        end
    end

    // State registers; reset discards held words and blocks any handshake that cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            full_q <= '0;
            occ_q  <= '0;
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            full_q <= full_d;
            occ_q  <= occ_d;
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    // Registered outputs.
    always_comb begin
        Out_valid = full_q;
        Occ       = occ_q;
        Data_out0 = data_q[0];
        Data_out1 = data_q[1];
        Data_out2 = data_q[2];
        Data_out3 = data_q[3];
    end

endmodule

// File: tb/tb_demux1to4_reg.sv
// Scoreboard bench for demux1to4_reg: the driver pushes accepted words into a
// pending queue, the monitor moves them into per-lane expectation queues and
// checks every lane, Occ and Out_valid after each rising edge.
module tb_demux1to4_reg;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  Data_in;
    logic [1:0]    Sel;
    logic          In_valid;
    logic          In_ready;
    logic [W-1:0]  Data_out0, Data_out1, Data_out2, Data_out3;
    logic [3:0]    Out_valid;
    logic [3:0]    Out_ready;
    logic [2:0]    Occ;

    always #5 clk = ~clk;

    demux1to4_reg #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .Data_in   (Data_in),
        .Sel       (Sel),
        .In_valid  (In_valid),
        .In_ready  (In_ready),
        .Data_out0 (Data_out0),
        .Data_out1 (Data_out1),
        .Data_out2 (Data_out2),
        .Data_out3 (Data_out3),
        .Out_valid (Out_valid),
        .Out_ready (Out_ready),
        .Occ       (Occ)
    );

    typedef struct packed {
        logic [1:0]   sel;
        logic [W-1:0] data;
    } txn_t;

    txn_t         pend_q[$];
    logic [W-1:0] lane_q[4][$];
    logic [W-1:0] last[4];
    bit           started = 0;
    int           n_vec = 0;
    int           n_err = 0;

    function automatic logic [W-1:0] dout(int k);
        case (k)
            0:       return Data_out0;
            1:       return Data_out1;
            2:       return Data_out2;
            default: return Data_out3;
        endcase
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; predicts In_ready and records the word if it will be taken.
    task automatic drive(input logic rst, input logic v, input logic [1:0] s,
                         input logic [W-1:0] d, input logic [3:0] r);
        logic exp_rdy;
        txn_t t;
        @(negedge clk);
        reset     = rst;
        In_valid  = v;
        Sel       = s;
        Data_in   = d;
        Out_ready = r;
        #1;
        if (started) begin
            exp_rdy = (lane_q[s].size() == 0) || r[s];
            check("in_ready", {31'b0, In_ready}, {31'b0, exp_rdy});
            if (!rst && v && exp_rdy) begin
                t.sel  = s;
                t.data = d;
                pend_q.push_back(t);
            end
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: retire drains, apply accepts, then compare the whole output state.
    always @(posedge clk) begin
        logic [3:0] exp_v;
        int         total;
        txn_t       t;
        #1;
        if (reset) begin
            pend_q.delete();
            for (int k = 0; k < 4; k++) begin
                lane_q[k].delete();
                last[k] = '0;
            end
            started = 1;
        end else if (started) begin
            for (int k = 0; k < 4; k++) begin
                if (lane_q[k].size() > 0 && Out_ready[k]) void'(lane_q[k].pop_front());
            end
            while (pend_q.size() > 0) begin
                t = pend_q.pop_front();
                lane_q[t.sel].push_back(t.data);
                last[t.sel] = t.data;
            end
        end
        if (started) begin
            total = 0;
            for (int k = 0; k < 4; k++) begin
                exp_v[k] = (lane_q[k].size() > 0);
                total += lane_q[k].size();
                check($sformatf("lane%0d_data", k), dout(k), last[k]);
            end
            check("out_valid", {28'b0, Out_valid}, {28'b0, exp_v});
            check("occ", {29'b0, Occ}, total);
        end
    end

    initial begin
        reset = 1'b1; In_valid = 1'b0; Sel = '0; Data_in = '0; Out_ready = '0;

        // Reset held two cycles with a valid input present.
        drive(1, 1, 2'd1, 32'hCAFE0001, 4'b0000);
        drive(1, 1, 2'd1, 32'hCAFE0002, 4'b0000);
        settle();
        check("rst_valid", {28'b0, Out_valid}, 0);
        check("rst_occ", {29'b0, Occ}, 0);
        check("rst_in_ready", {31'b0, In_ready}, 1);
        check("rst_data3", Data_out3, 0);

        // Steering into all four lanes with no consumer ready.
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, 2'(k), 32'h11111111 * (k + 1), 4'b0000);
        end
        settle();
        check("steer_valid", {28'b0, Out_valid}, 32'hF);
        check("steer_occ", {29'b0, Occ}, 4);
        check("steer_lane0", Data_out0, 32'h11111111);
        check("steer_lane3", Data_out3, 32'h44444444);

        // Back-pressure on full lane 2.
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 2'd2, 32'hDEADBEEF, 4'b0000);
            check("bp_in_ready", {31'b0, In_ready}, 0);
            settle();
            check("bp_lane2", Data_out2, 32'h33333333);
        end

        // Pass-through: lane 1 drains and refills in one cycle.
        drive(1, 0, 2'd0, 32'h0, 4'b0000);
        drive(0, 1, 2'd1, 32'h0000000A, 4'b0000);
        drive(0, 1, 2'd1, 32'h0000000B, 4'b0010);
        settle();
        check("pt_lane1", Data_out1, 32'h0000000B);
        check("pt_valid1", {31'b0, Out_valid[1]}, 1);
        check("pt_occ", {29'b0, Occ}, 1);

        // Mixed: accept into lane 3 while lanes 0 and 1 drain.
        drive(0, 1, 2'd0, 32'h0000000C, 4'b0000);
        drive(0, 1, 2'd2, 32'h0000000D, 4'b0000);
        settle();
        check("mix_occ_before", {29'b0, Occ}, 3);
        drive(0, 1, 2'd3, 32'h0000000E, 4'b0011);
        settle();
        check("mix_occ_after", {29'b0, Occ}, 2);
        check("mix_valid", {28'b0, Out_valid}, 32'hC);

        // Reset mid-operation with an accept pending.
        drive(0, 1, 2'd0, 32'h0000000F, 4'b0000);
        settle();
        check("rmid_occ_before", {29'b0, Occ}, 3);
        drive(1, 1, 2'd1, 32'h00000055, 4'b0000);
        settle();
        check("rmid_occ", {29'b0, Occ}, 0);
        check("rmid_valid", {28'b0, Out_valid}, 0);
        drive(0, 0, 2'd1, 32'h00000066, 4'b0000);
        settle();
        check("rmid_lane1", Data_out1, 0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                  2'($urandom_range(0, 3)), $urandom, 4'($urandom));
        end
        drive(0, 0, 2'd0, 32'h0, 4'b1111);
        settle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
